// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the 1-to-N packet router.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PARITY = 2'd2,
    CHECK  = 2'd3
  } router_state_e;

  // Header layout: low addr_w bits select the channel, the rest carry LEN.
  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-channel synchronous FIFO with registered read data.
// Optional idle-read flush is enabled by defining ROUTER_TIMEOUT_EN.
module router_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("router_fifo: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              do_wr, do_rd, flush;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = rd_data_q;

`ifdef ROUTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign flush = (to_cnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (flush || empty_o || rd_en_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // A flush discards everything, including a byte arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/router_1xn.sv
// 1-to-NCH packet router: header/payload/parity framing, parity check, per-channel FIFOs.
// Optional FIFO idle flush: define ROUTER_TIMEOUT_EN.
module router_1xn
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NCH     = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_vld,
  input  logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  err,
  output logic [NCH-1:0]        vld_out,
  input  logic [NCH-1:0]        renb,
  output logic [NCH*DATA_W-1:0] dout
);

  localparam int ADDR_W = $clog2(NCH);
  localparam int CNT_W  = DATA_W - ADDR_W;

  if (NCH < 2) begin : g_param_check
    $error("router_1xn: NCH must be >= 2");
  end

  router_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  len_q, cnt_q, cnt_d;
  logic [DATA_W-1:0] par_q;
  logic              par_bad_q;
  logic              err_q;

  logic [ADDR_W-1:0] hdr_a, tgt_addr;
  logic [CNT_W-1:0]  hdr_l;
  logic              tgt_ok, tgt_full, accept;
  logic [NCH-1:0]    full, empty, wr_en;

  assign hdr_a = ADDR_W'(hdr_addr(32'(din), ADDR_W));
  assign hdr_l = CNT_W'(hdr_len(32'(din), ADDR_W));

  // While idle the incoming byte is the header, so it names the target directly.
  assign tgt_addr = (state_q == IDLE) ? hdr_a : addr_q;
  assign tgt_ok   = (int'(tgt_addr) < NCH);
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_comb begin
    tgt_full = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(tgt_addr) == i) tgt_full = full[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      IDLE:         busy = pkt_vld && tgt_full;
      LOAD, PARITY: busy = tgt_full;
      CHECK:        busy = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  assign accept = pkt_vld && !busy;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_en[i] = accept && tgt_ok && (int'(tgt_addr) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      par_q     <= '0;
      par_bad_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          addr_q  <= hdr_a;
          len_q   <= hdr_l;
          cnt_q   <= '0;
          par_q   <= din;
          err_q   <= 1'b0;
          state_q <= (hdr_l == '0) ? PARITY : LOAD;
        end
        LOAD: if (accept) begin
          par_q <= par_q ^ din;
          cnt_q <= cnt_d;
          if (cnt_d == len_q) state_q <= PARITY;
        end
        PARITY: if (accept) begin
          par_bad_q <= (par_q != din);
          state_q   <= CHECK;
        end
        CHECK: begin
          err_q   <= par_bad_q || !tgt_ok;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    router_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en[g]),
      .wr_data_i(din),
      .rd_en_i  (renb[g]),
      .rd_data_o(dout[g*DATA_W +: DATA_W]),
      .full_o   (full[g]),
      .empty_o  (empty[g])
    );
    assign vld_out[g] = !empty[g];
  end

endmodule

// File: tb/tb_router_1xn.sv
// Scoreboard bench for router_1xn (NCH=3, DATA_W=8, DEPTH=16).
module tb_router_1xn;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_vld;
  logic [7:0]  din;
  logic        busy, err;
  logic [2:0]  vld_out;
  logic [2:0]  renb;
  logic [23:0] dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$], q1[$], q2[$];

  router_1xn #(.DATA_W(8), .NCH(3), .DEPTH(16), .TIMEOUT(30)) dut (
    .clk    (clk),
    .rst    (rst),
    .pkt_vld(pkt_vld),
    .din    (din),
    .busy   (busy),
    .err    (err),
    .vld_out(vld_out),
    .renb   (renb),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int ch, input logic [7:0] b);
    case (ch)
      0: q0.push_back(b);
      1: q1.push_back(b);
      2: q2.push_back(b);
      default: ;
    endcase
  endfunction

  function automatic logic pop_exp(input int ch, output logic [7:0] b);
    b = 8'h00;
    case (ch)
      0: if (q0.size() > 0) begin b = q0.pop_front(); return 1'b1; end
      1: if (q1.size() > 0) begin b = q1.pop_front(); return 1'b1; end
      2: if (q2.size() > 0) begin b = q2.pop_front(); return 1'b1; end
      default: ;
    endcase
    return 1'b0;
  endfunction

  // Monitor: every pop seen at an edge is compared against the scoreboard.
  logic [2:0] pops;
  always @(posedge clk) begin
    pops = rst ? 3'b000 : (renb & vld_out);
    #1;
    for (int c = 0; c < 3; c++) begin
      if (pops[c]) begin
        logic [7:0] e;
        if (pop_exp(c, e)) begin
          check($sformatf("dout_ch%0d", c), 32'(dout[c*8 +: 8]), 32'(e));
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop_ch%0d: got %0h expected no data", c, dout[c*8 +: 8]);
        end
      end
    end
  end

  task automatic send(input int ch, input logic [7:0] b);
    int n;
    push_exp(ch, b);
    @(negedge clk);
    pkt_vld = 1'b1;
    din     = b;
    n = 0;
    forever begin
      @(posedge clk);
      if (!busy) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0h still held, expected acceptance", b);
        break;
      end
    end
  endtask

  // Drop valid during CHECK and land just after the err update edge.
  task automatic end_pkt();
    @(negedge clk);
    pkt_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int ch);
    int n;
    @(negedge clk);
    renb[ch] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (!vld_out[ch]) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout_ch%0d: vld_out %b expected channel empty", ch, vld_out);
        break;
      end
    end
    renb[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded expected bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] par;
    int n;
    rst = 1'b1; pkt_vld = 1'b0; din = 8'h00; renb = 3'b000;
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_vld_out", 32'(vld_out), 32'h0);
    check("reset_dout", 32'(dout), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Good packet to ch1
    send(1, 8'h0D); send(1, 8'hA1); send(1, 8'hB2); send(1, 8'hC3); send(1, 8'hDD);
    end_pkt();
    check("good_err", 32'(err), 32'h0);
    check("good_vld_out", 32'(vld_out), 32'h2);
    drain(1);
    check("good_drained", 32'(vld_out), 32'h0);

    // Bad parity, then err clears on the next header
    send(1, 8'h0D); send(1, 8'hA1); send(1, 8'hB2); send(1, 8'hC3); send(1, 8'h00);
    end_pkt();
    check("badpar_err", 32'(err), 32'h1);
    send(0, 8'h04);
    #1;
    check("err_cleared_on_hdr", 32'(err), 32'h0);
    send(0, 8'h55); send(0, 8'h51);
    end_pkt();
    check("ch0_pkt_err", 32'(err), 32'h0);
    check("two_ch_vld", 32'(vld_out), 32'h3);
    drain(1);
    drain(0);

    // Fill ch0 with a 16-byte packet (LEN 14), then back-pressure a header
    par = 8'h38;
    send(0, 8'h38);
    for (int i = 1; i <= 14; i++) begin
      send(0, 8'(i));
      par = par ^ 8'(i);
    end
    send(0, par);
    end_pkt();
    check("full_pkt_err", 32'(err), 32'h0);
    check("full_vld_out", 32'(vld_out), 32'h1);
    @(negedge clk);
    pkt_vld = 1'b1;
    din     = 8'h04;
    #1;
    check("full_busy", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    check("full_busy_held", 32'(busy), 32'h1);
    renb[0] = 1'b1;
    @(negedge clk);
    renb[0] = 1'b0;
    check("busy_after_read", 32'(busy), 32'h0);
    push_exp(0, 8'h04);
    @(posedge clk);
    #1;
    check("hdr_taken_full_again", 32'(busy), 32'h1);
    @(negedge clk);
    renb[0] = 1'b1;
    send(0, 8'h55); send(0, 8'h51);
    end_pkt();
    check("bp_pkt_err", 32'(err), 32'h0);
    drain(0);

    // Invalid address 3, correct parity, still errors
    send(-1, 8'h07); send(-1, 8'h11); send(-1, 8'h16);
    end_pkt();
    check("badaddr_err", 32'(err), 32'h1);
    check("badaddr_no_write", 32'(vld_out), 32'h0);
    repeat (3) @(negedge clk);
    check("badaddr_no_write_later", 32'(vld_out), 32'h0);

    // LEN 0 packet to ch2, then leave it unread
    send(2, 8'h02); send(2, 8'h02);
    end_pkt();
    check("len0_err", 32'(err), 32'h0);
    check("len0_vld_out", 32'(vld_out), 32'h4);
    repeat (40) @(negedge clk);
`ifdef ROUTER_TIMEOUT_EN
    check("timeout_flushed", 32'(vld_out), 32'h0);
    q2.delete();
`else
    check("no_timeout_held", 32'(vld_out), 32'h4);
    drain(2);
`endif

    // Reset in the middle of a packet
    send(1, 8'h0D); send(1, 8'hA1); send(1, 8'hB2);
    @(negedge clk);
    pkt_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_vld_out", 32'(vld_out), 32'h0);
    check("midrst_dout", 32'(dout), 32'h0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    send(1, 8'h0D); send(1, 8'hA1); send(1, 8'hB2); send(1, 8'hC3); send(1, 8'hDD);
    end_pkt();
    check("post_rst_err", 32'(err), 32'h0);
    check("post_rst_vld_out", 32'(vld_out), 32'h2);
    drain(1);

    repeat (2) @(negedge clk);
    check("sb_left_ch0", 32'(q0.size()), 32'h0);
    check("sb_left_ch1", 32'(q1.size()), 32'h0);
    check("sb_left_ch2", 32'(q2.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_1xn.md
# router_1xn

Parametrised 1-to-N packet router, successor of the fixed 1x3 router. Accepts header/payload/parity packets on a single source port, checks parity, and steers each packet into one of NCH per-destination FIFOs, each read independently. Sits between the source driver side (`pkt_vld`/`din`/`busy`/`err`) and NCH destination consumers (`vld_out`/`renb`/`dout`).

## Interface
- `DATA_W`, default 8: byte width of `din`/`dout`.
- `NCH`, default 3: number of destination channels, ≥2.
- `DEPTH`, default 16: entries per channel FIFO, power of two.
- `TIMEOUT`, default 30: idle-read cycles before a channel FIFO is flushed; used only with `ROUTER_TIMEOUT_EN`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pkt_vld` in 1: source byte valid.
- `din` in DATA_W: source byte.
- `busy` out 1: source must hold `din`; byte not accepted this cycle.
- `err` out 1: parity or address error on the last packet.
- `vld_out` out NCH: bit i = FIFO i non-empty.
- `renb` in NCH: bit i = read request to FIFO i.
- `dout` out NCH*DATA_W: channel i at bits [i*DATA_W +: DATA_W].

## Operation
- Packet format: header, LEN payload bytes, parity byte. `pkt_vld` stays high on every byte.
- Header fields: `ADDR_W = $clog2(NCH)`. Address is `din[ADDR_W-1:0]`. LEN is `din[DATA_W-1:ADDR_W]`.
- LEN = 0 is legal: the packet is header then parity.
- Parity byte equals the XOR of the header and all payload bytes.
- Byte acceptance: a byte is accepted on a clock edge where `pkt_vld && !busy`.
- FSM states are IDLE, LOAD, PARITY, CHECK.
  - IDLE → LOAD on an accepted header with LEN > 0.
  - IDLE → PARITY on an accepted header with LEN = 0.
  - LOAD → PARITY after the LEN-th payload byte is accepted.
  - PARITY → CHECK when the parity byte is accepted.
  - CHECK → IDLE unconditionally after 1 cycle.
- Header, payload and parity bytes are all written to the FIFO of the addressed channel.
- Invalid address (addr ≥ NCH):
  - The packet is consumed normally but written nowhere.
  - `err` is set in CHECK regardless of parity.
- `busy` is combinational and high when any of these holds:
  - state is IDLE, `pkt_vld` is high, and the target FIFO is full;
  - state is LOAD or PARITY and the target FIFO is full;
  - state is CHECK.
- `err` is registered.
  - Set on the CHECK cycle when the running XOR ≠ parity byte, or the address is invalid.
  - Cleared when the next header is accepted.
  - Errored packets remain in the FIFO; discarding them is the consumer's job.
- Reads: `renb[i]` with `vld_out[i]` high pops FIFO i. `renb[i]` on an empty FIFO is ignored.
- `dout[i]` holds its last value when not reading.
- The running byte counter is ADDR_W..DATA_W bits wide and never wraps, since LEN ≤ 2^(DATA_W-ADDR_W)-1.
- FIFO pointers are `$clog2(DEPTH)+1` bits; the MSB distinguishes full from empty.

## Timing
- Reset values: FSM = IDLE; all FIFOs empty; `busy` = 0; `err` = 0; `vld_out` = 0; `dout` = 0.
- Write latency: a byte accepted at edge k is in the FIFO after edge k, so `vld_out[i]` is high in cycle k+1.
- Read latency: `renb[i]` sampled high at edge k gives valid `dout[i]` after edge k (1 cycle).
- Simultaneous read and write on the same FIFO are both performed. Occupancy is unchanged; full/empty flags stay as they were.
- A read that frees a slot at edge k drops the full-caused `busy` in cycle k+1.
- `err` is valid in the cycle after CHECK.
- Reset mid-packet: all state returns to reset values immediately. The partial packet stays lost.

## Configuration
- `ROUTER_TIMEOUT_EN` defined:
  - Each channel has a counter that increments while `vld_out[i] && !renb[i]` and resets to 0 on a read or when the FIFO is empty.
  - When the counter reaches TIMEOUT, FIFO i is flushed to empty at the next edge.
  - Flush wins over a same-cycle write. Later bytes of an in-flight packet are still written.
- `ROUTER_TIMEOUT_EN` undefined: no counters exist; FIFOs are never flushed; the `TIMEOUT` parameter is unused.

## Structure
- `router_pkg` holds:
  - the FSM state enum `router_state_e` (IDLE, LOAD, PARITY, CHECK);
  - the header field extraction functions `hdr_addr()` and `hdr_len()`, parametrised via ADDR_W.
- Sub-module `router_fifo`:
  - a synchronous FIFO with parameters DATA_W and DEPTH;
  - contains the optional flush/timeout logic;
  - instantiated NCH times in a generate loop.
- The top level holds the FSM, the parity accumulator, the byte counter, and `busy`/`err`.

## Test plan
Defaults for all scenarios: NCH=3, DATA_W=8, DEPTH=16.
- Good packet: header 0x0D (addr 1, LEN 3), payload A1 B2 C3, parity DD → `err`=0; ch1 reads 0D A1 B2 C3 DD; `vld_out`=3'b010 until drained.
- Bad parity: same packet with parity 0x00 → `err`=1 in the cycle after CHECK; `err` clears on the next header.
- Full back-pressure: fill ch0 to 16 entries with no reads, then send a header to ch0 → `busy`=1 and the header is held. One `renb[0]` read → `busy` falls the next cycle and the header is accepted.
- Invalid address: header 0x07 (addr 3) with LEN 1 → no FIFO written; `err`=1.
- Timeout (`ROUTER_TIMEOUT_EN`): packet to ch2 with `renb`=0 for 30 cycles → `vld_out[2]` falls. Without the macro, `vld_out[2]` stays high indefinitely.
- Reset mid-packet: assert `rst` after 2 payload bytes → all outputs return to reset values; the next good packet routes correctly.
